// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep chunked ripple adder with valid/ready handshake
// Optional PIPELINED_ADDER_SUB_EN adds io_sub (a - b via ~b and forced carry-in).
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_a,
    input  logic [WIDTH-1:0] io_b,
    input  logic             io_cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             io_sub,
`endif
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_sum,
    output logic             io_cout,
    output logic             io_overflow
);
    localparam int CHUNK = WIDTH / STAGES;

    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH");
    end

    // Stage k registers hold the operands it consumed (skew for later chunks),
    // the result bits produced so far, and the carry into stage k+1.
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
    logic [STAGES-1:0]            c_q, v_q;
    logic                         ovf_q;

    logic [STAGES-1:0][WIDTH-1:0] a_d, b_d, s_in, s_d;
    logic [STAGES-1:0]            c_in, c_d, v_d;
    logic                         ovf_d;

    logic             adv;
    logic [WIDTH-1:0] b0;
    logic             c0;
    logic             c, c_msb;

`ifdef PIPELINED_ADDER_SUB_EN
    assign b0 = io_sub ? ~io_b : io_b;
    assign c0 = io_sub | io_cin;
`else
    assign b0 = io_b;
    assign c0 = io_cin;
`endif

    assign a_d[0]  = io_a;
    assign b_d[0]  = b0;
    assign c_in[0] = c0;
    assign s_in[0] = '0;
    assign v_d[0]  = io_in_valid;

    for (genvar k = 1; k < STAGES; k++) begin : g_skew
        assign a_d[k]  = a_q[k-1];
        assign b_d[k]  = b_q[k-1];
        assign c_in[k] = c_q[k-1];
        assign s_in[k] = s_q[k-1];
        assign v_d[k]  = v_q[k-1];
    end

    always_comb begin
        s_d   = s_in;
        c_d   = '0;
        c     = 1'b0;
        c_msb = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            c = c_in[k];
            for (int i = 0; i < CHUNK; i++) begin
                c_msb = c;
                s_d[k][k*CHUNK+i] = a_d[k][k*CHUNK+i] ^ b_d[k][k*CHUNK+i] ^ c;
                c = (a_d[k][k*CHUNK+i] & b_d[k][k*CHUNK+i])
                  | (c & (a_d[k][k*CHUNK+i] ^ b_d[k][k*CHUNK+i]));
            end
            c_d[k] = c;
        end
        // After the loop c/c_msb belong to the final chunk: carry out of and into the MSB.
        ovf_d = c_msb ^ c;
    end

    assign adv = !v_q[STAGES-1] | io_out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
        end else if (adv) begin
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
        end
    end

    // Only the not-yet-added chunks of the skew registers are consumed downstream.
    logic unused_skew;
    assign unused_skew = ^{a_q, b_q};

    assign io_in_ready  = adv;
    assign io_out_valid = v_q[STAGES-1];
    assign io_sum       = s_q[STAGES-1];
    assign io_cout      = c_q[STAGES-1];
    assign io_overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench for pipelined_adder against an arithmetic reference
`timescale 1ns/1ps
module tb_pipelined_adder;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             io_in_valid = 1'b0;
    logic             io_cin = 1'b0;
    logic             io_out_ready = 1'b0;
    logic [WIDTH-1:0] io_a = '0;
    logic [WIDTH-1:0] io_b = '0;
`ifdef PIPELINED_ADDER_SUB_EN
    logic             io_sub = 1'b0;
`endif
    logic             io_in_ready, io_out_valid, io_cout, io_overflow;
    logic [WIDTH-1:0] io_sum;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    logic bp_en = 1'b0;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_a         (io_a),
        .io_b         (io_b),
        .io_cin       (io_cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .io_sub       (io_sub),
`endif
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_sum       (io_sum),
        .io_cout      (io_cout),
        .io_overflow  (io_overflow)
    );

    always #5 clock = ~clock;

    // Reference: plain integer arithmetic, unsigned for sum/carry and signed for overflow.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        res_t   r;
        longint ua, ub, sa, sb, ci, u, s;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        ci = cin;
        if (sub) begin
            u      = ua - ub;
            s      = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            u      = ua + ub + ci;
            s      = sa + sb + ci;
            r.cout = (u >= 2**WIDTH);
        end
        r.sum = u[WIDTH-1:0];
        r.ovf = (s > 2**(WIDTH-1) - 1) || (s < -(2**(WIDTH-1)));
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, output int waits);
        @(posedge clock);
        #1;
        io_a = a;
        io_b = b;
        io_cin = cin;
        io_in_valid = 1'b1;
`ifdef PIPELINED_ADDER_SUB_EN
        io_sub = sub;
`endif
        waits = 0;
        forever begin
            @(negedge clock);
            if (io_in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                break;
            end
            waits++;
            if (waits > 50) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: io_in_ready stayed 0 for %0d cycles, expected 1", waits);
                break;
            end
        end
    endtask

    task automatic idle();
        @(posedge clock);
        #1 io_in_valid = 1'b0;
    endtask

    always @(posedge clock) begin
        if (bp_en) begin
            #1 io_out_ready = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clock) begin
        if (!reset && io_out_valid && io_out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got sum %0h, expected no result", io_sum);
            end else begin
                mon_e = exp_q.pop_front();
                check("sum", 32'(io_sum), 32'(mon_e.sum));
                check("cout", 32'(io_cout), 32'(mon_e.cout));
                check("overflow", 32'(io_overflow), 32'(mon_e.ovf));
            end
        end
    end

    initial begin
        int             w, lat, cnt;
        logic           seen;
        logic [WIDTH-1:0] held;
        logic [WIDTH-1:0] ra, rb;
        logic           rsub;

        repeat (2) @(posedge clock);
        #1;
        check("reset_out_valid", 32'(io_out_valid), 0);
        check("reset_sum", 32'(io_sum), 0);
        check("reset_cout", 32'(io_cout), 0);
        check("reset_overflow", 32'(io_overflow), 0);
        io_out_ready = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        // Carry across the chunk boundary, with latency measurement.
        send(8'h0F, 8'h01, 1'b0, 1'b0, w);
        idle();
        lat = 1;
        @(negedge clock);
        while (!io_out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("latency", 32'(lat), 32'(STAGES));
        repeat (2) @(posedge clock);

        send(8'hFF, 8'h01, 1'b1, 1'b0, w);
        send(8'h7F, 8'h01, 1'b0, 1'b0, w);
        idle();
        repeat (4) @(posedge clock);

        for (int i = 0; i < 10; i++) begin
            send(WIDTH'(i), WIDTH'(2 * i), 1'b0, 1'b0, w);
            check("in_ready_b2b", 32'(w), 0);
        end
        idle();
        repeat (4) @(posedge clock);

        // Backpressure: fill, stall, then drain.
        @(posedge clock);
        #1 io_out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0, 1'b0, w);
        send(8'h33, 8'h44, 1'b1, 1'b0, w);
        idle();
        @(negedge clock);
        held = io_sum;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("stall_in_ready", 32'(io_in_ready), 0);
            check("stall_out_valid", 32'(io_out_valid), 1);
            check("stall_sum_held", 32'(io_sum), 32'(held));
        end
        @(posedge clock);
        #1 io_out_ready = 1'b1;
        repeat (6) @(posedge clock);
        check("drain_after_stall", 32'(exp_q.size()), 0);

        // Asynchronous reset with two operands in flight.
        send(8'h21, 8'h05, 1'b0, 1'b0, w);
        send(8'h40, 8'h02, 1'b1, 1'b0, w);
        idle();
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        check("async_rst_out_valid", 32'(io_out_valid), 0);
        check("async_rst_sum", 32'(io_sum), 0);
        check("async_rst_cout", 32'(io_cout), 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (io_out_valid) seen = 1'b1;
        end
        check("no_stale_after_reset", 32'(seen), 0);

`ifdef PIPELINED_ADDER_SUB_EN
        send(8'h05, 8'h07, 1'b0, 1'b1, w);
        send(8'h80, 8'h01, 1'b0, 1'b1, w);
        send(8'h80, 8'h01, 1'b0, 1'b0, w);
        idle();
        repeat (4) @(posedge clock);
`endif

        // Randomised traffic with random output backpressure and input gaps.
        bp_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) idle();
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
`ifdef PIPELINED_ADDER_SUB_EN
            rsub = 1'($urandom_range(0, 1));
`else
            rsub = 1'b0;
`endif
            send(ra, rb, 1'($urandom_range(0, 1)), rsub, w);
        end
        idle();
        bp_en = 1'b0;
        @(posedge clock);
        #1 io_out_ready = 1'b1;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 100) begin
            @(posedge clock);
            cnt++;
        end
        repeat (2) @(posedge clock);
        check("final_drain_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the single-cycle ripple adder.
- Splits a WIDTH-bit addition into STAGES equal chunks. Each chunk is a ripple of full-adder cells followed by a register, and the chunk carry is registered into the next stage.
- Adds a valid/ready handshake on input and output, a carry-in, and a signed-overflow flag.
- Used as the arithmetic leaf in the datapath wherever timing needs a multi-cycle add.

Parameters:
- WIDTH, 8: operand/result width in bits. Must be ≥ 1.
- STAGES, 2: number of pipeline stages/chunks. Must divide WIDTH; CHUNK = WIDTH/STAGES. Elaboration fails otherwise.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_in_valid  in  1  operand set valid.
- io_in_ready  out  1  block can accept operands this cycle.
- io_a  in  WIDTH  operand A.
- io_b  in  WIDTH  operand B.
- io_cin  in  1  carry into bit 0.
- io_out_valid  out  1  result valid.
- io_out_ready  in  1  consumer accepts result.
- io_sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- io_cout  out  1  carry out of bit WIDTH-1.
- io_overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: all stage valid bits, partial sums, carries and skew registers go to 0 asynchronously. io_out_valid=0, io_sum=0, io_cout=0, io_overflow=0.
  - Asserting reset mid-operation discards all in-flight data. No result is emitted for it.
- Pipeline enable: adv = !io_out_valid | io_out_ready.
  - io_in_ready = adv (combinational; no dependence on io_in_valid).
  - The whole pipeline shifts on every edge where adv=1. It holds every register when adv=0.
  - Bubbles are not compressed: an invalid stage still occupies its slot.
- Transfers: input transfer = io_in_valid & io_in_ready at the edge. Output transfer = io_out_valid & io_out_ready.
- Stage k (0..STAGES-1):
  - Adds bits [k*CHUNK +: CHUNK] of a and b plus carry c_k. c_0 = io_cin; c_k = registered cout of stage k-1.
  - Registers the chunk sum, cout and valid bit.
  - Unprocessed upper operand chunks and lower result chunks travel in skew registers alongside.
- Latency: operands accepted in cycle c appear with io_out_valid=1 in cycle c+STAGES, provided adv=1 throughout.
- Throughput: 1 result/cycle when io_out_ready=1 continuously.
- Outputs come straight from the final-stage registers; no combinational path from inputs to io_sum, io_cout or io_overflow.
- io_overflow: computed inside stage STAGES-1 from the carry into bit WIDTH-1 and the carry out of it. Registered with the sum.
- Backpressure: while io_out_valid=1 and io_out_ready=0, io_sum, io_cout and io_overflow are held stable and io_in_ready=0.
- Full pipeline with simultaneous output transfer and input transfer: both occur in the same cycle; no loss, no duplication.
- Wrap-around: results are mod 2^WIDTH; the extra bit appears only on io_cout.
- STAGES=1: degenerates to a registered ripple adder with 1-cycle latency.

Optional Feature:
- Macro: PIPELINED_ADDER_SUB_EN.
- Defined:
  - Adds input port io_sub (1 bit), sampled with the operands.
  - When io_sub=1: stage 0 uses ~b as operand B and forces c_0 = 1 (io_cin ignored), so io_sum = a - b mod 2^WIDTH.
  - io_cout = 1 means no borrow. io_overflow is the signed subtraction overflow.
  - When io_sub=0: behaviour is identical to the undefined case.
- Undefined: no io_sub port; addition only.

Test Plan (WIDTH=8, STAGES=2 unless stated):
- Accept a=0x0F, b=0x01, cin=0 in cycle 1, io_out_ready=1 -> cycle 3: io_out_valid=1, io_sum=0x10, io_cout=0, io_overflow=0. Carry crosses the chunk boundary.
- a=0xFF, b=0x01, cin=1 -> io_sum=0x01, io_cout=1, io_overflow=0. Then a=0x7F, b=0x01, cin=0 -> io_sum=0x80, io_cout=0, io_overflow=1.
- Back-to-back stream of a=i, b=2i for i=0..9 with io_in_valid=1 and io_out_ready=1 -> 10 consecutive valid results 3i in order, io_in_ready=1 every cycle.
- Fill the pipeline, then hold io_out_ready=0 for 4 cycles -> io_in_ready=0, io_sum held stable. Release -> results drain in order; none lost or duplicated.
- Assert reset asynchronously between clock edges with 2 operands in flight -> io_out_valid=0 and io_sum=0 immediately. After release, no stale result appears.
- PIPELINED_ADDER_SUB_EN defined: a=0x05, b=0x07, io_sub=1 -> io_sum=0xFE, io_cout=0. Then a=0x80, b=0x01, io_sub=1 -> io_sum=0x7F, io_overflow=1.
